// File: rtl/wtb_mem_sched_if.sv
// Bundle of voice, loader and wavetable-memory signals around the wavetable scheduler.
// master is the scheduler side, slave is the voices/loader/memory side.
interface wtb_mem_sched_if #(
  parameter int VOICE_NUM = 4,
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 8
);
  logic                        sampleRate;
  logic [VOICE_NUM*ADDR_W-1:0] voiceAddr;
  logic [VOICE_NUM-1:0]        voiceActive;
  logic                        ldReq;
  logic [ADDR_W-1:0]           ldAddr;
  logic [DATA_W-1:0]           ldData;
  logic                        ldGnt;
  logic                        memEn;
  logic                        memWe;
  logic [ADDR_W-1:0]           memAddr;
  logic [DATA_W-1:0]           memWdata;
  logic [DATA_W-1:0]           memRdata;
  logic [VOICE_NUM*DATA_W-1:0] sampleOut;
  logic                        sampleValid;
  logic                        busy;
  logic                        overrun;

  modport master (
    input  sampleRate, voiceAddr, voiceActive, ldReq, ldAddr, ldData, memRdata,
    output ldGnt, memEn, memWe, memAddr, memWdata, sampleOut, sampleValid, busy, overrun
  );

  modport slave (
    output sampleRate, voiceAddr, voiceActive, ldReq, ldAddr, ldData, memRdata,
    input  ldGnt, memEn, memWe, memAddr, memWdata, sampleOut, sampleValid, busy, overrun
  );
endinterface

// File: rtl/wtb_mem_sched.sv
// Shares one single-port wavetable memory between VOICE_NUM voice read slots per sample
// strobe and loader writes granted while no fetch burst is in flight.
module wtb_mem_sched #(
  parameter int VOICE_NUM = 4,
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  wtb_mem_sched_if.master bus
);
  localparam int SLOT_W = (VOICE_NUM > 1) ? $clog2(VOICE_NUM) : 1;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                      state_q;
  logic [SLOT_W-1:0]           slot_q;
  logic [CNT_W-1:0]            drainCnt_q;
  logic [VOICE_NUM*ADDR_W-1:0] shadowAddr_q;
  logic [VOICE_NUM-1:0]        shadowActive_q;
  logic                        pipeValid_q [RD_LAT];
  logic [SLOT_W-1:0]           pipeIdx_q   [RD_LAT];
  logic [VOICE_NUM*DATA_W-1:0] capture_q;
  logic [VOICE_NUM*DATA_W-1:0] captureD;
  logic [VOICE_NUM*DATA_W-1:0] sampleOut_q;
  logic                        sampleValid_q;
  logic                        busy_q;
  logic                        overrun_q;
  logic                        issueRead;
  logic                        canAccept;

  // busy_q stays high through the publish cycle, so that cycle still rejects strobes and writes
  assign canAccept = (state_q == IDLE) && !busy_q;
  assign issueRead = (state_q == ISSUE) && shadowActive_q[slot_q];

  always_comb begin
    bus.ldGnt    = 1'b0;
    bus.memEn    = 1'b0;
    bus.memWe    = 1'b0;
    bus.memAddr  = '0;
    bus.memWdata = '0;
    if (state_q == ISSUE) begin
      bus.memEn   = issueRead;
      bus.memAddr = shadowAddr_q[int'(slot_q)*ADDR_W +: ADDR_W];
    end else if (canAccept && !bus.sampleRate && bus.ldReq) begin
      bus.ldGnt    = 1'b1;
      bus.memEn    = 1'b1;
      bus.memWe    = 1'b1;
      bus.memAddr  = bus.ldAddr;
      bus.memWdata = bus.ldData;
    end
  end

  always_comb begin
    captureD = capture_q;
    if ((state_q == ISSUE) && !shadowActive_q[slot_q]) begin
      captureD[int'(slot_q)*DATA_W +: DATA_W] = '0;
    end
    if (pipeValid_q[RD_LAT-1]) begin
      captureD[int'(pipeIdx_q[RD_LAT-1])*DATA_W +: DATA_W] = bus.memRdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      slot_q         <= '0;
      drainCnt_q     <= '0;
      shadowAddr_q   <= '0;
      shadowActive_q <= '0;
      capture_q      <= '0;
      sampleOut_q    <= '0;
      sampleValid_q  <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      for (int k = 0; k < RD_LAT; k++) begin
        pipeValid_q[k] <= 1'b0;
        pipeIdx_q[k]   <= '0;
      end
    end else begin
      sampleValid_q <= 1'b0;
      capture_q     <= captureD;
      for (int k = RD_LAT - 1; k > 0; k--) begin
        pipeValid_q[k] <= pipeValid_q[k-1];
        pipeIdx_q[k]   <= pipeIdx_q[k-1];
      end
      pipeValid_q[0] <= issueRead;
      pipeIdx_q[0]   <= slot_q;

      if (bus.sampleRate && busy_q) begin
        overrun_q <= 1'b1;
      end
      if (sampleValid_q) begin
        busy_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (bus.sampleRate && !busy_q) begin
            shadowAddr_q   <= bus.voiceAddr;
            shadowActive_q <= bus.voiceActive;
            slot_q         <= '0;
            busy_q         <= 1'b1;
            state_q        <= ISSUE;
          end
        end
        ISSUE: begin
          if (slot_q == SLOT_W'(VOICE_NUM - 1)) begin
            drainCnt_q <= CNT_W'(RD_LAT);
            state_q    <= DRAIN;
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end
        DRAIN: begin
          drainCnt_q <= drainCnt_q - 1'b1;
          // The last read lands in this cycle, so publish the merged capture buffer
          if (drainCnt_q == CNT_W'(1)) begin
            sampleOut_q   <= captureD;
            sampleValid_q <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sampleOut   = sampleOut_q;
  assign bus.sampleValid = sampleValid_q;
  assign bus.busy        = busy_q;
  assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_wtb_mem_sched.sv
// Randomised bench for wtb_mem_sched with a transaction-level reference model, a memory
// model with fixed read latency, and directed scenarios pinned by literal expectations.
module tb_wtb_mem_sched;
  localparam int V  = 4;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int RL = 2;
  localparam logic [V*AW-1:0] ADDR_A = {13'h040, 13'h030, 13'h020, 13'h010};
  localparam logic [V*AW-1:0] ADDR_B = {13'h040, 13'h030, 13'h020, 13'h101};

  logic clk = 1'b0;
  logic rst_ni;
  int   cyc = 0;
  int   checkCount = 0;
  int   passCount = 0;

  wtb_mem_sched_if #(.VOICE_NUM(V), .ADDR_W(AW), .DATA_W(DW)) bus ();

  wtb_mem_sched #(.VOICE_NUM(V), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: unknown-looking filler on non-read cycles so stray captures show up
  logic [DW-1:0] mem    [1<<AW];
  logic [DW-1:0] refMem [1<<AW];
  logic [DW-1:0] rdPipe [RL];

  always @(posedge clk) begin
    if (bus.memEn && bus.memWe) mem[bus.memAddr] <= bus.memWdata;
    rdPipe[0] <= (bus.memEn && !bus.memWe) ? mem[bus.memAddr] : 8'hEE;
    for (int k = 1; k < RL; k++) rdPipe[k] <= rdPipe[k-1];
  end
  assign bus.memRdata = rdPipe[RL-1];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: one burst record with its strobe cycle, snapshot and publish time
  bit                inBurst = 1'b0;
  int                tStart = 0;
  logic [AW-1:0]     snapAddr [V];
  bit                snapAct  [V];
  logic [V*DW-1:0]   burstOut = '0;
  logic [V*DW-1:0]   heldOut = '0;
  bit                expOverrun = 1'b0;

  always @(negedge clk) begin : modelBlk
    bit busyNow;
    bit pub;
    bit issuing;
    bit gnt;
    int slot;
    if (!rst_ni) begin
      inBurst    = 1'b0;
      heldOut    = '0;
      expOverrun = 1'b0;
    end else begin
      busyNow = inBurst && (cyc > tStart) && (cyc <= tStart + V + RL + 1);
      pub     = inBurst && (cyc == tStart + V + RL + 1);
      issuing = inBurst && (cyc > tStart) && (cyc <= tStart + V);
      if (pub) heldOut = burstOut;
      checkOutput("busy", bus.busy, busyNow);
      checkOutput("sample_valid", bus.sampleValid, pub);
      checkOutput("sample_out", bus.sampleOut, heldOut);
      checkOutput("overrun", bus.overrun, expOverrun);
      if (issuing) begin
        slot = cyc - tStart - 1;
        checkOutput("ld_gnt_in_burst", bus.ldGnt, 0);
        checkOutput("mem_en_read", bus.memEn, snapAct[slot]);
        checkOutput("mem_we_read", bus.memWe, 0);
        if (snapAct[slot]) checkOutput("mem_addr_read", bus.memAddr, snapAddr[slot]);
      end else begin
        gnt = bus.ldReq && !bus.sampleRate && !busyNow;
        checkOutput("ld_gnt", bus.ldGnt, gnt);
        checkOutput("mem_en", bus.memEn, gnt);
        if (gnt) begin
          checkOutput("mem_we_write", bus.memWe, 1);
          checkOutput("mem_addr_write", bus.memAddr, bus.ldAddr);
          checkOutput("mem_wdata", bus.memWdata, bus.ldData);
          refMem[bus.ldAddr] = bus.ldData;
        end
      end
      if (pub) inBurst = 1'b0;
      if (bus.sampleRate) begin
        if (busyNow) expOverrun = 1'b1;
        else begin
          inBurst = 1'b1;
          tStart  = cyc;
          for (int i = 0; i < V; i++) begin
            snapAddr[i] = bus.voiceAddr[i*AW +: AW];
            snapAct[i]  = bus.voiceActive[i];
            burstOut[i*DW +: DW] = snapAct[i] ? refMem[snapAddr[i]] : '0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sr, input logic [V*AW-1:0] addrs,
                               input logic [V-1:0] act, input logic req,
                               input logic [AW-1:0] la, input logic [DW-1:0] ld);
    tick();
    bus.sampleRate  = sr;
    bus.voiceAddr   = addrs;
    bus.voiceActive = act;
    bus.ldReq       = req;
    bus.ldAddr      = la;
    bus.ldData      = ld;
  endtask

  // Counts cycles until sample_valid, with a bounded budget
  task automatic waitValid(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      bus.sampleRate = 1'b0;
      #3;
      if (bus.sampleValid) begin
        n = k;
        break;
      end
    end
    if (n < 0) checkOutput("sample_valid_timeout", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int validCount;
    for (int a = 0; a < (1 << AW); a++) begin
      mem[a]    = DW'(a);
      refMem[a] = DW'(a);
    end
    rst_ni          = 1'b0;
    bus.sampleRate  = 1'b0;
    bus.voiceAddr   = '0;
    bus.voiceActive = '0;
    bus.ldReq       = 1'b0;
    bus.ldAddr      = '0;
    bus.ldData      = '0;
    repeat (3) @(posedge clk);
    #3;
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_valid", bus.sampleValid, 0);
    checkOutput("reset_sample_out", bus.sampleOut, 0);
    checkOutput("reset_overrun", bus.overrun, 0);
    checkOutput("reset_mem_en", bus.memEn, 0);
    tick();
    rst_ni = 1'b1;
    repeat (3) applyStimulus(0, '0, '0, 0, '0, '0);

    // All voices active
    applyStimulus(1, ADDR_A, 4'hF, 0, '0, '0);
    applyStimulus(0, ADDR_A, 4'hF, 0, '0, '0);
    #3;
    checkOutput("first_issue_addr", bus.memAddr, 13'h010);
    waitValid(n);
    checkOutput("publish_latency", n + 1, V + RL + 1);
    checkOutput("all_active_out", bus.sampleOut, 32'h40302010);
    tick(); #3;
    checkOutput("valid_one_pulse", bus.sampleValid, 0);
    checkOutput("busy_after_publish", bus.busy, 0);

    // Voices 1 and 3 silent
    applyStimulus(1, ADDR_A, 4'b0101, 0, '0, '0);
    applyStimulus(0, ADDR_A, 4'b0101, 0, '0, '0);
    tick(); #3;
    checkOutput("inactive_slot_en", bus.memEn, 0);
    waitValid(n);
    checkOutput("latency_partial", n, 5);
    checkOutput("partial_out", bus.sampleOut, 32'h00300010);

    // Back-to-back loader writes then read-back
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, ADDR_A, 4'hF, 1, AW'(13'h100 + k), DW'(8'hA1 + k));
      #3;
      checkOutput("ld_gnt_b2b", bus.ldGnt, 1);
    end
    applyStimulus(0, ADDR_A, 4'hF, 0, '0, '0);
    applyStimulus(1, ADDR_B, 4'hF, 0, '0, '0);
    waitValid(n);
    checkOutput("latency_readback", n, V + RL + 1);
    checkOutput("readback_out", bus.sampleOut, 32'h403020A2);

    // Strobe beats a simultaneous loader request
    applyStimulus(1, ADDR_A, 4'hF, 1, 13'h1FF, 8'h5A);
    #3;
    checkOutput("strobe_priority", bus.ldGnt, 0);
    waitValid(n);
    checkOutput("gnt_blocked_in_valid", bus.ldGnt, 0);
    tick(); #3;
    checkOutput("gnt_after_valid", bus.ldGnt, 1);
    applyStimulus(0, ADDR_A, 4'hF, 0, '0, '0);

    // Second strobe during a burst
    applyStimulus(1, ADDR_A, 4'hF, 0, '0, '0);
    applyStimulus(0, ADDR_A, 4'hF, 0, '0, '0);
    applyStimulus(0, ADDR_A, 4'hF, 0, '0, '0);
    applyStimulus(1, ADDR_A, 4'hF, 0, '0, '0);
    validCount = 0;
    for (int j = 4; j <= 15; j++) begin
      tick();
      bus.sampleRate = 1'b0;
      #3;
      if (bus.sampleValid) validCount++;
      if (j == 4) checkOutput("overrun_set", bus.overrun, 1);
      if (j == 7) checkOutput("busy_in_valid", bus.busy, 1);
      if (j == 8) checkOutput("busy_low_after", bus.busy, 0);
    end
    checkOutput("single_publish", validCount, 1);
    checkOutput("overrun_sticky", bus.overrun, 1);

    // Reset mid-burst
    applyStimulus(1, ADDR_B, 4'hF, 0, '0, '0);
    applyStimulus(0, ADDR_B, 4'hF, 0, '0, '0);
    tick();
    rst_ni = 1'b0;
    #3;
    checkOutput("midreset_sample_out", bus.sampleOut, 0);
    checkOutput("midreset_busy", bus.busy, 0);
    checkOutput("midreset_valid", bus.sampleValid, 0);
    tick();
    rst_ni = 1'b1;
    #3;
    checkOutput("overrun_cleared", bus.overrun, 0);
    validCount = 0;
    for (int j = 0; j < 10; j++) begin
      tick(); #3;
      if (bus.sampleValid) validCount++;
    end
    checkOutput("no_publish_after_abort", validCount, 0);
    applyStimulus(1, ADDR_A, 4'hF, 0, '0, '0);
    waitValid(n);
    checkOutput("latency_after_reset", n, V + RL + 1);
    checkOutput("out_after_reset", bus.sampleOut, 32'h40302010);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      logic [V*AW-1:0] ra;
      for (int i = 0; i < V; i++) ra[i*AW +: AW] = AW'($urandom_range(0, 1023));
      applyStimulus(($urandom_range(0, 7) == 0), ra, V'($urandom),
                    $urandom_range(0, 1) == 1, AW'($urandom_range(0, 1023)), DW'($urandom));
    end
    repeat (12) applyStimulus(0, '0, '0, 0, '0, '0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
